prt_dprx_scrm: RTL and testbench

- Per-lane DisplayPort RX descrambler.
- Sits directly downstream of the RX control register block and the lane aligner, ahead of the lane merge/MSA parser.
- Consumes CTL_LNK_EN and CTL_SCRM_EN from the control block.
- Runs the DP 16-bit LFSR (x^16+x^5+x^4+x^3+1) across P_SPL symbols per clock, reseeds on Scrambler Reset (SR), and descrambles data symbols while passing K-symbols through unchanged.

---
 rtl/prt_dprx_scrm_pkg.sv | 36 +++
 rtl/prt_dprx_scrm.sv | 156 +++++++++++++++
 tb/tb_prt_dprx_scrm.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prt_dprx_scrm_pkg.sv
// ----------------------------------------------------------------------------
// prt_dprx_scrm_pkg
// Shared definitions for the DisplayPort scrambler/descrambler pair.
// Holds the 16-bit LFSR geometry (x^16+x^5+x^4+x^3+1), the K-codes the link
// layer cares about, and lfsr_step8(), which advances the LFSR by one symbol
// and returns the keystream byte used for that symbol.
// The TX scrambler imports the same function, so both ends stay bit-exact.
// No ports (package).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package prt_dprx_scrm_pkg;

   localparam int                  C_LFSR_W    = 16;
   // Feedback lands on bits 3, 4 and 5; bit 0 takes the feedback directly
   // through the shift.
   localparam logic [C_LFSR_W-1:0] C_LFSR_TAPS = 16'h0038;

   localparam logic [7:0]          C_K_SR      = 8'h1C;   // K28.0, scrambler reset
   localparam logic [7:0]          C_K_BS      = 8'hBC;   // K28.5, blanking start

   // Returns {next_lfsr, keystream_byte}. Keystream bit i is the LFSR MSB
   // as it stands before the i-th single-bit step.
   function automatic logic [C_LFSR_W+7:0] lfsr_step8(input logic [C_LFSR_W-1:0] lfsr);
      logic [C_LFSR_W-1:0] v_l;
      logic [7:0]          v_ks;
      v_l  = lfsr;
      v_ks = '0;
      for (int i = 0; i < 8; i++) begin
         v_ks[i] = v_l[C_LFSR_W-1];
         v_l     = {v_l[C_LFSR_W-2:0], v_l[C_LFSR_W-1]}
                   ^ ({C_LFSR_W{v_l[C_LFSR_W-1]}} & C_LFSR_TAPS);
      end
      return {v_l, v_ks};
   endfunction

endpackage

// File: rtl/prt_dprx_scrm.sv
// ----------------------------------------------------------------------------
// prt_dprx_scrm
// Per-lane DisplayPort RX descrambler. Sits after the lane aligner and ahead
// of lane merge / MSA parsing. Runs the DP LFSR across P_SPL symbols per
// clock, reseeds on every Scrambler Reset (K28.0), descrambles data symbols
// and passes K-symbols through untouched. One clock of latency, no
// backpressure.
//
// Optional feature macro: PRT_DPRX_SCRM_LOCK_EN
//   defined   : LNK_LOCK_OUT tracks SR activity (set on SR, cleared after
//               1024 valid beats without SR or when the link is disabled).
//   undefined : LNK_LOCK_OUT is CTL_LNK_EN_IN delayed by one clock.
//
// Ports
//   CLK_IN          link clock
//   RST_IN          asynchronous reset, active low
//   CTL_LNK_EN_IN   link enable (0 holds LFSR at seed, forces outputs to 0)
//   CTL_SCRM_EN_IN  descrambling enable (LFSR keeps running when 0)
//   LNK_DAT_IN      P_SPL symbols, symbol 0 in [7:0] is earliest
//   LNK_K_IN        K-flag per symbol
//   LNK_VLD_IN      input beat valid
//   LNK_DAT_OUT     descrambled symbols
//   LNK_K_OUT       K-flags aligned with LNK_DAT_OUT
//   LNK_VLD_OUT     output beat valid
//   LNK_LOCK_OUT    scrambler lock status
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module prt_dprx_scrm
   import prt_dprx_scrm_pkg::*;
#(
   parameter int                  P_SPL    = 2,
   parameter logic [C_LFSR_W-1:0] P_SEED   = 16'hFFFF,
   parameter logic [7:0]          P_SR_SYM = C_K_SR
)(
   input  logic                 CLK_IN,
   input  logic                 RST_IN,
   input  logic                 CTL_LNK_EN_IN,
   input  logic                 CTL_SCRM_EN_IN,
   input  logic [P_SPL*8-1:0]   LNK_DAT_IN,
   input  logic [P_SPL-1:0]     LNK_K_IN,
   input  logic                 LNK_VLD_IN,
   output logic [P_SPL*8-1:0]   LNK_DAT_OUT,
   output logic [P_SPL-1:0]     LNK_K_OUT,
   output logic                 LNK_VLD_OUT,
   output logic                 LNK_LOCK_OUT
);

   logic [C_LFSR_W-1:0] r_lfsr;
   logic [P_SPL*8-1:0]  r_dat;
   logic [P_SPL-1:0]    r_k;
   logic                r_vld;
   logic                r_lock;

   logic [C_LFSR_W-1:0] w_chain;
   logic [C_LFSR_W+7:0] w_step;
   logic [7:0]          w_sym;
   logic [C_LFSR_W-1:0] w_lfsr_nxt;
   logic [P_SPL*8-1:0]  w_dat_nxt;
`ifdef PRT_DPRX_SCRM_LOCK_EN
   logic                w_sr_any;
   logic [9:0]          r_beat_cnt;
`endif

   // Walk the symbols in time order. An SR leaves its symbol alone and hands
   // the seed to the next symbol, so with several SRs in one beat only the
   // last one decides the end-of-beat LFSR. Every other symbol costs eight
   // LFSR steps whether or not it is descrambled, which keeps the receiver
   // in step with the transmitter across bypass periods and K-symbols.
   always_comb begin
      w_chain   = r_lfsr;
      w_step    = '0;
      w_sym     = '0;
      w_dat_nxt = LNK_DAT_IN;
`ifdef PRT_DPRX_SCRM_LOCK_EN
      w_sr_any  = 1'b0;
`endif
      for (int s = 0; s < P_SPL; s++) begin
         w_sym  = LNK_DAT_IN[s*8 +: 8];
         w_step = lfsr_step8(w_chain);
         if (LNK_K_IN[s] && (w_sym == P_SR_SYM)) begin
            w_chain  = P_SEED;
`ifdef PRT_DPRX_SCRM_LOCK_EN
            w_sr_any = 1'b1;
`endif
         end else begin
            if (!LNK_K_IN[s] && CTL_SCRM_EN_IN) begin
               w_dat_nxt[s*8 +: 8] = w_sym ^ w_step[7:0];
            end
            w_chain = w_step[C_LFSR_W+7:8];
         end
      end
      w_lfsr_nxt = w_chain;
   end

   // Link disable behaves like a soft reset. Invalid beats leave data, K and
   // the LFSR untouched; only the valid flag drops.
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         r_lfsr <= P_SEED;
         r_dat  <= '0;
         r_k    <= '0;
         r_vld  <= 1'b0;
      end else if (!CTL_LNK_EN_IN) begin
         r_lfsr <= P_SEED;
         r_dat  <= '0;
         r_k    <= '0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= LNK_VLD_IN;
         if (LNK_VLD_IN) begin
            r_lfsr <= w_lfsr_nxt;
            r_dat  <= w_dat_nxt;
            r_k    <= LNK_K_IN;
         end
      end
   end

`ifdef PRT_DPRX_SCRM_LOCK_EN
   // Lock follows SR activity. The beat counter restarts on every SR; the
   // 1024th consecutive valid beat without one drops lock and the counter
   // parks at its maximum until the next SR.
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         r_lock     <= 1'b0;
         r_beat_cnt <= '0;
      end else if (!CTL_LNK_EN_IN) begin
         r_lock     <= 1'b0;
         r_beat_cnt <= '0;
      end else if (LNK_VLD_IN) begin
         if (w_sr_any) begin
            r_lock     <= 1'b1;
            r_beat_cnt <= '0;
         end else if (r_beat_cnt == 10'h3FF) begin
            r_lock     <= 1'b0;
         end else begin
            r_beat_cnt <= r_beat_cnt + 10'd1;
         end
      end
   end
`else
   // Without lock tracking, status simply mirrors the link enable.
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         r_lock <= 1'b0;
      end else begin
         r_lock <= CTL_LNK_EN_IN;
      end
   end
`endif

   assign LNK_DAT_OUT  = r_dat;
   assign LNK_K_OUT    = r_k;
   assign LNK_VLD_OUT  = r_vld;
   assign LNK_LOCK_OUT = r_lock;

endmodule

// File: tb/tb_prt_dprx_scrm.sv
// ----------------------------------------------------------------------------
// tb_prt_dprx_scrm
// Scoreboard bench for prt_dprx_scrm. Two instances run side by side
// (P_SPL=4 as "A", P_SPL=2 as "B"). Each driven beat pushes the expected
// next-cycle output onto a per-instance queue; the following negedge pops
// and compares. Round-trip traffic comes from a TX scrambler model.
// Honours PRT_DPRX_SCRM_LOCK_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prt_dprx_scrm;

   typedef struct packed {
      logic        vld;
      logic [31:0] dat;
      logic [3:0]  k;
      logic        lock;
   } expT;

   typedef struct packed {
      logic [15:0] lfsr;
      logic [31:0] lastDat;
      logic [3:0]  lastK;
      logic        lock;
      logic [9:0]  cnt;
   } mstT;

   logic        clk;
   logic        rstN;
   logic        lnkEn;
   logic        scrmEn;
   logic        vldIn;
   logic [31:0] datInA;
   logic [3:0]  kInA;
   logic [15:0] datInB;
   logic [1:0]  kInB;
   logic [31:0] datOutA;
   logic [3:0]  kOutA;
   logic        vldOutA;
   logic        lockOutA;
   logic [15:0] datOutB;
   logic [1:0]  kOutB;
   logic        vldOutB;
   logic        lockOutB;

   int          nChecks;
   int          nFails;
   expT         qA[$];
   expT         qB[$];
   mstT         stA;
   mstT         stB;
   logic [15:0] txA;
   logic [15:0] txB;
   logic        ovrA;
   logic        ovrB;
   logic [31:0] ovrDatA;
   logic [15:0] ovrDatB;

   prt_dprx_scrm #(.P_SPL(4)) dutA (
      .CLK_IN         (clk),
      .RST_IN         (rstN),
      .CTL_LNK_EN_IN  (lnkEn),
      .CTL_SCRM_EN_IN (scrmEn),
      .LNK_DAT_IN     (datInA),
      .LNK_K_IN       (kInA),
      .LNK_VLD_IN     (vldIn),
      .LNK_DAT_OUT    (datOutA),
      .LNK_K_OUT      (kOutA),
      .LNK_VLD_OUT    (vldOutA),
      .LNK_LOCK_OUT   (lockOutA)
   );

   prt_dprx_scrm #(.P_SPL(2)) dutB (
      .CLK_IN         (clk),
      .RST_IN         (rstN),
      .CTL_LNK_EN_IN  (lnkEn),
      .CTL_SCRM_EN_IN (scrmEn),
      .LNK_DAT_IN     (datInB),
      .LNK_K_IN       (kInB),
      .LNK_VLD_IN     (vldIn),
      .LNK_DAT_OUT    (datOutB),
      .LNK_K_OUT      (kOutB),
      .LNK_VLD_OUT    (vldOutB),
      .LNK_LOCK_OUT   (lockOutB)
   );

   // 100 MHz link clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference scrambler; scrambling and descrambling are the same XOR, so
   // this serves as both the TX model and the RX expectation
   function automatic void scrmBeat(input logic [15:0] li, input int n, input logic [31:0] d,
                                    input logic [3:0] k, input logic en,
                                    output logic [31:0] o, output logic [15:0] lo, output logic sr);
      logic [15:0] l;
      logic        fb;
      l  = li;
      o  = d;
      sr = 1'b0;
      for (int s = 0; s < n; s++) begin
         if (k[s] && (d[s*8 +: 8] == 8'h1C)) begin
            l  = 16'hFFFF;
            sr = 1'b1;
         end else begin
            for (int i = 0; i < 8; i++) begin
               if (!k[s] && en) o[s*8+i] = d[s*8+i] ^ l[15];
               fb = l[15];
               l  = {l[14:0], fb} ^ (fb ? 16'h0038 : 16'h0000);
            end
         end
      end
      lo = l;
   endfunction

   // Predicts the next-cycle outputs of one instance
   task automatic modelStep(input int n, input logic [31:0] d, input logic [3:0] k, input logic vld,
                            input logic ovr, input logic [31:0] ovrDat,
                            input mstT sIn, output mstT sOut, output expT e);
      logic [31:0] o;
      logic [15:0] nl;
      logic        sr;
      sOut = sIn;
      e    = '0;
      if (!lnkEn) begin
         sOut      = '0;
         sOut.lfsr = 16'hFFFF;
      end else begin
         if (vld) begin
            scrmBeat(sIn.lfsr, n, d, k, scrmEn, o, nl, sr);
            sOut.lfsr    = nl;
            sOut.lastDat = ovr ? ovrDat : o;
            sOut.lastK   = k;
`ifdef PRT_DPRX_SCRM_LOCK_EN
            if (sr) begin
               sOut.lock = 1'b1;
               sOut.cnt  = '0;
            end else if (sIn.cnt == 10'd1023) begin
               sOut.lock = 1'b0;
            end else begin
               sOut.cnt = sIn.cnt + 10'd1;
            end
`endif
         end
`ifndef PRT_DPRX_SCRM_LOCK_EN
         sOut.lock = 1'b1;
`endif
         e.vld  = vld;
         e.dat  = sOut.lastDat;
         e.k    = sOut.lastK;
         e.lock = sOut.lock;
      end
   endtask

   // Drives one beat and queues what each instance must show next cycle
   task automatic applyStimulus(input logic [31:0] dA, input logic [3:0] kA,
                                input logic [15:0] dB, input logic [1:0] kB, input logic vld);
      expT eA;
      expT eB;
      mstT nA;
      mstT nB;
      datInA = dA;
      kInA   = kA;
      datInB = dB;
      kInB   = kB;
      vldIn  = vld;
      modelStep(4, dA, kA, vld, ovrA, ovrDatA, stA, nA, eA);
      stA = nA;
      qA.push_back(eA);
      modelStep(2, {16'h0, dB}, {2'b00, kB}, vld, ovrB, {16'h0, ovrDatB}, stB, nB, eB);
      stB = nB;
      qB.push_back(eB);
      ovrA = 1'b0;
      ovrB = 1'b0;
   endtask

   // Pops the scoreboard and compares against both instances
   task automatic compareBeat();
      expT e;
      if (qA.size() != 0) begin
         e = qA.pop_front();
         checkOutput("A.vld",  32'(vldOutA),  32'(e.vld));
         checkOutput("A.dat",  datOutA,       e.dat);
         checkOutput("A.k",    32'(kOutA),    32'(e.k));
         checkOutput("A.lock", 32'(lockOutA), 32'(e.lock));
      end
      if (qB.size() != 0) begin
         e = qB.pop_front();
         checkOutput("B.vld",  32'(vldOutB),  32'(e.vld));
         checkOutput("B.dat",  32'(datOutB),  e.dat);
         checkOutput("B.k",    32'(kOutB),    32'(e.k));
         checkOutput("B.lock", 32'(lockOutB), 32'(e.lock));
      end
   endtask

   // One clock: check the previous beat, then drive the next
   task automatic cycle(input logic lnk, input logic scrm, input logic [31:0] dA, input logic [3:0] kA,
                        input logic [15:0] dB, input logic [1:0] kB, input logic vld);
      @(negedge clk);
      compareBeat();
      lnkEn  = lnk;
      scrmEn = scrm;
      applyStimulus(dA, kA, dB, kB, vld);
   endtask

   // TX-scrambled random traffic with BS K-symbols; expected output is the
   // plaintext. In bypass the TX LFSR still runs but raw A5 data is sent.
   task automatic roundTrip(input int beats, input bit bypass, input bit doSr);
      logic [31:0] pA;
      logic [31:0] sA;
      logic [15:0] pB;
      logic [31:0] sB;
      logic [3:0]  kA;
      logic [1:0]  kB;
      logic [15:0] nl;
      logic        sr;
      logic        vld;
      logic        srBeat;
      for (int b = 0; b < beats; b++) begin
         srBeat = doSr && ((b % 512) == 0);
         vld    = srBeat || ($urandom_range(7) != 0);
         pA     = bypass ? 32'hA5A5A5A5 : $urandom;
         pB     = bypass ? 16'hA5A5 : 16'($urandom);
         kA     = '0;
         kB     = '0;
         for (int s = 0; s < 4; s++) begin
            if ($urandom_range(7) == 0) begin
               kA[s]          = 1'b1;
               pA[s*8 +: 8]   = 8'hBC;
            end
         end
         for (int s = 0; s < 2; s++) begin
            if ($urandom_range(7) == 0) begin
               kB[s]          = 1'b1;
               pB[s*8 +: 8]   = 8'hBC;
            end
         end
         if (srBeat) begin
            kA[0]    = 1'b1;
            pA[7:0]  = 8'h1C;
            kB[0]    = 1'b1;
            pB[7:0]  = 8'h1C;
         end
         sA = pA;
         sB = {16'h0, pB};
         if (vld) begin
            scrmBeat(txA, 4, pA, kA, 1'b1, sA, nl, sr);
            txA = nl;
            scrmBeat(txB, 2, {16'h0, pB}, {2'b00, kB}, 1'b1, sB, nl, sr);
            txB = nl;
            if (bypass) begin
               sA = pA;
               sB = {16'h0, pB};
            end
            ovrA    = 1'b1;
            ovrDatA = pA;
            ovrB    = 1'b1;
            ovrDatB = pB;
         end
         cycle(1'b1, !bypass, sA, kA, sB[15:0], kB, vld);
      end
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      rstN    = 1'b0;
      lnkEn   = 1'b0;
      scrmEn  = 1'b0;
      vldIn   = 1'b0;
      datInA  = '0;
      kInA    = '0;
      datInB  = '0;
      kInB    = '0;
      ovrA    = 1'b0;
      ovrB    = 1'b0;
      ovrDatA = '0;
      ovrDatB = '0;
      stA     = '0;
      stA.lfsr = 16'hFFFF;
      stB     = '0;
      stB.lfsr = 16'hFFFF;
      txA     = 16'hFFFF;
      txB     = 16'hFFFF;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst.A.vld",  32'(vldOutA),  32'd0);
      checkOutput("rst.A.dat",  datOutA,       32'd0);
      checkOutput("rst.A.lock", 32'(lockOutA), 32'd0);
      checkOutput("rst.B.vld",  32'(vldOutB),  32'd0);
      checkOutput("rst.B.dat",  32'(datOutB),  32'd0);
      checkOutput("rst.B.lock", 32'(lockOutB), 32'd0);
      rstN = 1'b1;

      // Link disabled: everything forced to zero
      repeat (4) cycle(1'b0, 1'b1, $urandom, 4'h0, 16'($urandom), 2'b00, 1'b1);

      // Enable with an idle beat, then zeros from the seed: DP reference bytes
      cycle(1'b1, 1'b1, 32'h0, 4'h0, 16'h0, 2'b00, 1'b0);
      ovrA = 1'b1; ovrDatA = 32'h14C017FF;
      ovrB = 1'b1; ovrDatB = 16'h17FF;
      cycle(1'b1, 1'b1, 32'h0, 4'h0, 16'h0, 2'b00, 1'b1);

      // SR in symbol 1, then zeros: B must produce FF, 17, C0, 14
      cycle(1'b1, 1'b1, 32'h00001C55, 4'b0010, 16'h1C55, 2'b10, 1'b1);
      ovrB = 1'b1; ovrDatB = 16'h17FF;
      cycle(1'b1, 1'b1, 32'h0, 4'h0, 16'h0, 2'b00, 1'b1);
      ovrB = 1'b1; ovrDatB = 16'h14C0;
      cycle(1'b1, 1'b1, 32'h0, 4'h0, 16'h0, 2'b00, 1'b1);

      // Two SRs in one 4-symbol beat; next beat restarts from the seed
      ovrA = 1'b1; ovrDatA = 32'h1C17FF1C;
      ovrB = 1'b1; ovrDatB = 16'hFF1C;
      cycle(1'b1, 1'b1, 32'h1C00001C, 4'b1001, 16'h001C, 2'b01, 1'b1);
      ovrA = 1'b1; ovrDatA = 32'h14C017FF;
      ovrB = 1'b1; ovrDatB = 16'hC017;
      cycle(1'b1, 1'b1, 32'h0, 4'h0, 16'h0, 2'b00, 1'b1);

      // Round trip, bypass with A5, then re-enable without a fresh SR
      roundTrip(600, 1'b0, 1'b1);
      roundTrip(20,  1'b1, 1'b0);
      roundTrip(60,  1'b0, 1'b0);

      // Long SR-free run, then an SR, then drop the link mid-stream
      repeat (1100) cycle(1'b1, 1'b1, $urandom, 4'h0, 16'($urandom), 2'b00, 1'b1);
      cycle(1'b1, 1'b1, 32'h0000001C, 4'b0001, 16'h001C, 2'b01, 1'b1);
      cycle(1'b1, 1'b1, $urandom, 4'h0, 16'($urandom), 2'b00, 1'b1);
      cycle(1'b0, 1'b1, $urandom, 4'h0, 16'($urandom), 2'b00, 1'b1);
      cycle(1'b0, 1'b1, $urandom, 4'h0, 16'($urandom), 2'b00, 1'b1);
      @(negedge clk);
      compareBeat();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
